// File: rtl/lcd_bus_receiver_if.sv
// lcd_bus_receiver_if
// Groups the 4-bit character-LCD bus and the decoded-byte outputs of
// lcd_bus_receiver into one bundle.
//   master : drives the LCD strobe/RS/RW/nibble lines, observes the decode
//   slave  : receives the LCD lines, drives the decoded byte, address, status
interface lcd_bus_receiver_if;
  logic       iLCD_E;
  logic       iLCD_RS;
  logic       iLCD_RW;
  logic [3:0] iLCD_Data;
  logic [7:0] oByte;
  logic       oIsData;
  logic       oValid;
  logic [6:0] oAddress;
  logic       oInitDone;
  logic       oError;
  logic [1:0] oErrorCode;

  modport master (
    output iLCD_E, iLCD_RS, iLCD_RW, iLCD_Data,
    input  oByte, oIsData, oValid, oAddress, oInitDone, oError, oErrorCode
  );

  modport slave (
    input  iLCD_E, iLCD_RS, iLCD_RW, iLCD_Data,
    output oByte, oIsData, oValid, oAddress, oInitDone, oError, oErrorCode
  );
endinterface

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver
// Display-side model/monitor of an HD44780-style 4-bit LCD bus. Decodes the
// initialization nibbles (3,3,3,2) and then nibble-pair transfers into whole
// command/data bytes, tracks the DDRAM address and latches the first protocol
// or timing violation.
// Ports:
//   Clock - system clock, rising edge
//   Reset - asynchronous, active-low reset
//   bus   - lcd_bus_receiver_if.slave: iLCD_E/RS/RW/Data in;
//           oByte, oIsData, oValid, oAddress, oInitDone, oError, oErrorCode out
module lcd_bus_receiver #(
  parameter int MIN_E_HIGH = 12
) (
  input logic               Clock,
  input logic               Reset,
  lcd_bus_receiver_if.slave bus
);

  localparam int CountWidth = $clog2(MIN_E_HIGH + 1);
  localparam logic [CountWidth-1:0] MinHigh = CountWidth'(MIN_E_HIGH);

  typedef enum logic [2:0] {
    INIT3A, INIT3B, INIT3C, INIT2, HIGH, LOW
  } stateT;

  stateT                 state, stateNext;
  logic                  eQ;
  logic [CountWidth-1:0] eHighCount;
  logic [3:0]            dataQ;
  logic                  rsQ, rwQ;
  logic [3:0]            highNibble, highNibbleNext;
  logic                  highRs, highRsNext;
  logic [7:0]            byteQ, byteNext;
  logic                  isDataQ, isDataNext;
  logic                  validQ, validNext;
  logic [6:0]            addrQ, addrNext;
  logic                  initDoneQ, initDoneNext;
  logic                  errorQ;
  logic [1:0]            errorCodeQ;
  logic                  errHit;
  logic [1:0]            errCodeHit;
  logic                  fallEdge, acceptEdge, shortEdge;

  // Address after a valid byte: data writes advance with the two-line wrap
  // (end of line 1 jumps to line 2, end of line 2 back to the start).
  function automatic logic [6:0] nextAddress(input logic isData,
                                             input logic [7:0] b,
                                             input logic [6:0] a);
    logic [6:0] r;
    r = a;
    if (isData) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else if (b == 8'h01 || b == 8'h02 || b == 8'h03) begin
      r = 7'h00;
    end else if (b[7]) begin
      r = b[6:0];
    end
    return r;
  endfunction

  // Read transfers are ignored entirely, so they never count as short pulses.
  assign fallEdge   = eQ && !bus.iLCD_E;
  assign acceptEdge = fallEdge && !rwQ && (eHighCount >= MinHigh);
  assign shortEdge  = fallEdge && !rwQ && (eHighCount < MinHigh);

  // Edge detect, saturating E-high counter, and capture of the bus values
  // from the last cycle E was high (used when the falling edge is seen).
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      eQ         <= 1'b0;
      eHighCount <= '0;
      dataQ      <= 4'h0;
      rsQ        <= 1'b0;
      rwQ        <= 1'b0;
    end else begin
      eQ <= bus.iLCD_E;
      if (bus.iLCD_E) begin
        dataQ <= bus.iLCD_Data;
        rsQ   <= bus.iLCD_RS;
        rwQ   <= bus.iLCD_RW;
        if (eHighCount < MinHigh) eHighCount <= eHighCount + 1'b1;
      end else begin
        eHighCount <= '0;
      end
    end
  end

  // State and output registers; errors latch only the first occurrence.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= INIT3A;
      highNibble <= 4'h0;
      highRs     <= 1'b0;
      byteQ      <= 8'h00;
      isDataQ    <= 1'b0;
      validQ     <= 1'b0;
      addrQ      <= 7'h00;
      initDoneQ  <= 1'b0;
      errorQ     <= 1'b0;
      errorCodeQ <= 2'b00;
    end else begin
      state      <= stateNext;
      highNibble <= highNibbleNext;
      highRs     <= highRsNext;
      byteQ      <= byteNext;
      isDataQ    <= isDataNext;
      validQ     <= validNext;
      addrQ      <= addrNext;
      initDoneQ  <= initDoneNext;
      if (errHit && !errorQ) begin
        errorQ     <= 1'b1;
        errorCodeQ <= errCodeHit;
      end
    end
  end

  // Next-state and next-output decode for each accepted falling edge.
  always_comb begin
    stateNext      = state;
    highNibbleNext = highNibble;
    highRsNext     = highRs;
    byteNext       = byteQ;
    isDataNext     = isDataQ;
    validNext      = 1'b0;
    addrNext       = addrQ;
    initDoneNext   = initDoneQ;
    errHit         = 1'b0;
    errCodeHit     = 2'b00;
    if (shortEdge) begin
      errHit     = 1'b1;
      errCodeHit = 2'b11;
    end else if (acceptEdge) begin
      unique case (state)
        INIT3A, INIT3B, INIT3C, INIT2: begin
          if (!rsQ && dataQ == ((state == INIT2) ? 4'h2 : 4'h3)) begin
            unique case (state)
              INIT3A:  stateNext = INIT3B;
              INIT3B:  stateNext = INIT3C;
              INIT3C:  stateNext = INIT2;
              default: begin
                stateNext    = HIGH;
                initDoneNext = 1'b1;
              end
            endcase
          end else begin
            errHit     = 1'b1;
            errCodeHit = 2'b01;
          end
        end
        HIGH: begin
          highNibbleNext = dataQ;
          highRsNext     = rsQ;
          stateNext      = LOW;
        end
        LOW: begin
          stateNext = HIGH;
          if (rsQ == highRs) begin
            validNext  = 1'b1;
            byteNext   = {highNibble, dataQ};
            isDataNext = rsQ;
            addrNext   = nextAddress(rsQ, {highNibble, dataQ}, addrQ);
          end else begin
            errHit     = 1'b1;
            errCodeHit = 2'b10;
          end
        end
        default: stateNext = INIT3A;
      endcase
    end
  end

  assign bus.oByte      = byteQ;
  assign bus.oIsData    = isDataQ;
  assign bus.oValid     = validQ;
  assign bus.oAddress   = addrQ;
  assign bus.oInitDone  = initDoneQ;
  assign bus.oError     = errorQ;
  assign bus.oErrorCode = errorCodeQ;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver
// Directed bench for lcd_bus_receiver: init sequence, command/data decode,
// address wrap, RS mismatch, short E pulse, read cycles, init error and
// asynchronous mid-byte reset. Expected values are hand-computed constants.
module tb_lcd_bus_receiver;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  lcd_bus_receiver_if bus();

  lcd_bus_receiver #(.MIN_E_HIGH(12)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One E pulse of highCycles cycles; returns in the cycle after the
  // falling edge has been registered (outputs for that edge visible).
  task automatic applyStimulus(input logic [3:0] nib, input logic rs,
                               input logic rw, input int highCycles);
    @(negedge Clock);
    bus.iLCD_Data = nib;
    bus.iLCD_RS   = rs;
    bus.iLCD_RW   = rw;
    bus.iLCD_E    = 1'b1;
    repeat (highCycles) @(negedge Clock);
    bus.iLCD_E = 1'b0;
    @(negedge Clock);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic rs);
    applyStimulus(b[7:4], rs, 1'b0, 12);
    checkOutput("noValidAfterHigh", {7'd0, bus.oValid}, 8'd0);
    applyStimulus(b[3:0], rs, 1'b0, 12);
  endtask

  task automatic checkByte(input string tag, input logic [7:0] b,
                           input logic isData, input logic [6:0] addr);
    checkOutput({tag, ".valid"}, {7'd0, bus.oValid}, 8'd1);
    checkOutput({tag, ".byte"}, bus.oByte, b);
    checkOutput({tag, ".isData"}, {7'd0, bus.oIsData}, {7'd0, isData});
    checkOutput({tag, ".addr"}, {1'b0, bus.oAddress}, {1'b0, addr});
  endtask

  task automatic runInit();
    applyStimulus(4'h3, 1'b0, 1'b0, 12);
    applyStimulus(4'h3, 1'b0, 1'b0, 12);
    applyStimulus(4'h3, 1'b0, 1'b0, 12);
    checkOutput("init.notDoneYet", {7'd0, bus.oInitDone}, 8'd0);
    applyStimulus(4'h2, 1'b0, 1'b0, 12);
    checkOutput("init.done", {7'd0, bus.oInitDone}, 8'd1);
    checkOutput("init.noValid", {7'd0, bus.oValid}, 8'd0);
  endtask

  task automatic applyReset();
    @(negedge Clock);
    bus.iLCD_E = 1'b0;
    Reset      = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    bus.iLCD_E    = 1'b0;
    bus.iLCD_RS   = 1'b0;
    bus.iLCD_RW   = 1'b0;
    bus.iLCD_Data = 4'h0;
    repeat (3) @(negedge Clock);
    checkOutput("reset.byte", bus.oByte, 8'h00);
    checkOutput("reset.valid", {7'd0, bus.oValid}, 8'd0);
    checkOutput("reset.addr", {1'b0, bus.oAddress}, 8'h00);
    checkOutput("reset.initDone", {7'd0, bus.oInitDone}, 8'd0);
    checkOutput("reset.error", {6'd0, bus.oError, 1'b0} | {6'd0, bus.oErrorCode}, 8'd0);
    Reset = 1'b1;

    // Init and command/data decode with address tracking
    runInit();
    checkOutput("init.error", {7'd0, bus.oError}, 8'd0);
    sendByte(8'h28, 1'b0);
    checkByte("cmd28", 8'h28, 1'b0, 7'h00);
    @(negedge Clock);
    checkOutput("validOneCycle", {7'd0, bus.oValid}, 8'd0);
    sendByte(8'hA7, 1'b0);
    checkByte("cmdA7", 8'hA7, 1'b0, 7'h27);
    sendByte(8'h41, 1'b1);
    checkByte("data41", 8'h41, 1'b1, 7'h40);
    sendByte(8'hE7, 1'b0);
    checkByte("cmdE7", 8'hE7, 1'b0, 7'h67);
    sendByte(8'h55, 1'b1);
    checkByte("data55", 8'h55, 1'b1, 7'h00);
    sendByte(8'h85, 1'b0);
    checkByte("cmd85", 8'h85, 1'b0, 7'h05);
    sendByte(8'h01, 1'b0);
    checkByte("cmd01", 8'h01, 1'b0, 7'h00);
    sendByte(8'h30, 1'b1);
    checkByte("data30", 8'h30, 1'b1, 7'h01);
    sendByte(8'h28, 1'b0);
    checkByte("cmd28b", 8'h28, 1'b0, 7'h01);
    sendByte(8'h02, 1'b0);
    checkByte("cmd02", 8'h02, 1'b0, 7'h00);

    // RS mismatch inside a byte, then recovery
    applyStimulus(4'h4, 1'b1, 1'b0, 12);
    applyStimulus(4'h2, 1'b0, 1'b0, 12);
    checkOutput("rsMis.valid", {7'd0, bus.oValid}, 8'd0);
    checkOutput("rsMis.error", {7'd0, bus.oError}, 8'd1);
    checkOutput("rsMis.code", {6'd0, bus.oErrorCode}, 8'd2);
    sendByte(8'h42, 1'b1);
    checkByte("data42", 8'h42, 1'b1, 7'h01);

    // Short E pulse and read cycles
    applyReset();
    runInit();
    applyStimulus(4'h4, 1'b1, 1'b0, 11);
    checkOutput("short.valid", {7'd0, bus.oValid}, 8'd0);
    checkOutput("short.error", {7'd0, bus.oError}, 8'd1);
    checkOutput("short.code", {6'd0, bus.oErrorCode}, 8'd3);
    sendByte(8'h31, 1'b1);
    checkByte("data31", 8'h31, 1'b1, 7'h01);
    applyStimulus(4'h5, 1'b0, 1'b1, 12);
    checkOutput("read.valid", {7'd0, bus.oValid}, 8'd0);
    checkOutput("read.code", {6'd0, bus.oErrorCode}, 8'd3);
    sendByte(8'h33, 1'b1);
    checkByte("data33", 8'h33, 1'b1, 7'h02);

    // Init error holds the state; async reset mid-byte
    applyReset();
    applyStimulus(4'h2, 1'b0, 1'b0, 12);
    checkOutput("initErr.error", {7'd0, bus.oError}, 8'd1);
    checkOutput("initErr.code", {6'd0, bus.oErrorCode}, 8'd1);
    applyStimulus(4'h3, 1'b0, 1'b0, 12);
    applyStimulus(4'h3, 1'b0, 1'b0, 12);
    applyStimulus(4'h2, 1'b0, 1'b0, 12);
    checkOutput("initErr.notDone", {7'd0, bus.oInitDone}, 8'd0);
    applyStimulus(4'h3, 1'b0, 1'b0, 12);
    applyStimulus(4'h2, 1'b0, 1'b0, 12);
    checkOutput("initErr.done", {7'd0, bus.oInitDone}, 8'd1);
    checkOutput("initErr.codeHeld", {6'd0, bus.oErrorCode}, 8'd1);
    sendByte(8'h48, 1'b1);
    checkByte("data48", 8'h48, 1'b1, 7'h01);
    applyStimulus(4'h6, 1'b1, 1'b0, 12);
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    checkOutput("asyncRst.byte", bus.oByte, 8'h00);
    checkOutput("asyncRst.isData", {7'd0, bus.oIsData}, 8'd0);
    checkOutput("asyncRst.addr", {1'b0, bus.oAddress}, 8'h00);
    checkOutput("asyncRst.initDone", {7'd0, bus.oInitDone}, 8'd0);
    checkOutput("asyncRst.error", {7'd0, bus.oError}, 8'd0);
    checkOutput("asyncRst.code", {6'd0, bus.oErrorCode}, 8'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    runInit();
    sendByte(8'h57, 1'b1);
    checkByte("data57", 8'h57, 1'b1, 7'h01);
    checkOutput("final.error", {7'd0, bus.oError}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_bus_receiver.md
# lcd_bus_receiver

Receiving end of the 4-bit character-LCD bus driven by the `LCD` controller (`SF_D`, `LCD_E`, `LCD_RS`, `LCD_RW`). It decodes the HD44780-style initialization nibbles and the nibble-pair byte transfers into whole command/data bytes. It tracks the display's DDRAM address and flags protocol and timing violations. It sits in the bench and the on-chip debug path as the display-side model/monitor; all inputs are in the `Clock` domain.

## Interface
- `MIN_E_HIGH`, 12: minimum `iLCD_E` high time in `Clock` cycles; shorter pulses are rejected.
- `Clock`, input, 1: system clock, rising edge.
- `Reset`, input, 1: asynchronous, active-low reset.
- `iLCD_E`, input, 1: LCD enable strobe; a transfer completes on its falling edge.
- `iLCD_RS`, input, 1: 0 = command, 1 = data.
- `iLCD_RW`, input, 1: 0 = write, 1 = read.
- `iLCD_Data`, input, 4: nibble bus (`SF_D`).
- `oByte`, output, 8: last decoded byte.
- `oIsData`, output, 1: RS of `oByte`.
- `oValid`, output, 1: one-cycle pulse when `oByte`/`oIsData` update.
- `oAddress`, output, 7: current DDRAM address.
- `oInitDone`, output, 1: initialization nibble sequence completed.
- `oError`, output, 1: sticky error flag.
- `oErrorCode`, output, 2: first error seen. 00 = none, 01 = bad init nibble, 10 = RS mismatch within a byte, 11 = short E pulse.

## Operation
- Edge detect:
  - Register `iLCD_E` as `e_q`.
  - A falling edge is a cycle where `e_q`=1 and `iLCD_E`=0.
  - The captured nibble and RS are the `iLCD_Data`/`iLCD_RS` values registered in the last cycle `iLCD_E` was high.
- E-high counter: counts cycles while `iLCD_E`=1 and saturates at `MIN_E_HIGH`.
  - If a falling edge arrives with count < `MIN_E_HIGH`, the edge is discarded.
  - That edge sets error 11; the FSM does not advance.
- Edges with RW=1 are ignored: no state change, no error.
- FSM states: `INIT3A` → `INIT3B` → `INIT3C` → `INIT2` → `HIGH` ⇄ `LOW`.
  - Each INIT state accepts exactly one nibble with RS=0.
  - Expected nibbles are 0x3, 0x3, 0x3 and 0x2 respectively.
  - A wrong nibble or RS=1 in an INIT state sets error 01 and the FSM stays in that state.
  - `INIT2` → `HIGH` sets `oInitDone`=1. No `oValid` is produced during INIT states.
  - `HIGH`: store the nibble as bits [7:4] and store RS; go to `LOW`.
  - `LOW`:
    - If RS equals the stored RS: form the byte {high, nibble}, pulse `oValid`, update `oAddress`, go to `HIGH`.
    - If RS differs: set error 10, discard the byte, go to `HIGH`.
- Address update, applied on a valid byte:
  - Command 0x01 (clear) or 0x02/0x03 (home): address = 0x00.
  - Command with bit 7 set: address = byte[6:0].
  - Other commands: no change.
  - Data byte: the write goes to the current address, then the address advances. 0x27 → 0x40; 0x67 → 0x00; any other address → +1.
- Errors: `oError` and `oErrorCode` latch only the first error and hold until reset. Decoding continues after an error.

## Timing
- Reset values (asynchronous, while `Reset`=0):
  - FSM = `INIT3A`.
  - `oByte`=0x00, `oIsData`=0, `oValid`=0, `oAddress`=0x00, `oInitDone`=0, `oError`=0, `oErrorCode`=00.
  - E-high counter = 0, `e_q` = 0.
- Latency: the falling edge is sampled at rising edge N. `oValid`, `oByte`, `oIsData`, `oAddress` and the error outputs are registered at edge N and visible during cycle N+1.
- `oValid` is exactly one cycle wide. Back-to-back bytes need at least 2 falling edges, so `oValid` is never high on consecutive cycles.
- `oAddress` reflects the post-update value in the same cycle `oValid` is high.
- A reset asserted mid-byte, between the HIGH and LOW nibbles, discards the partial byte and restarts at `INIT3A`.
- Minimum accepted pulse: E high for exactly `MIN_E_HIGH` cycles.

## Test plan
- Init: drive nibbles 0x3, 0x3, 0x3, 0x2 (RS=0, E high 12 cycles each) → `oInitDone`=1 the cycle after the 4th falling edge, no `oValid`, `oError`=0.
- Command, after init: send 0x28 as nibbles 0x2, 0x8 with RS=0 → `oValid` pulse with `oByte`=0x28, `oIsData`=0, `oAddress`=0x00.
- Data and wrap:
  - Send command 0xA7 → `oAddress`=0x27.
  - Send data 0x41 → `oValid`, `oIsData`=1, `oAddress`=0x40.
  - Send command 0xE7, then data → `oAddress`=0x00.
  - Send command 0x01 → `oAddress`=0x00.
- RS mismatch: high nibble with RS=1, low nibble with RS=0 → no `oValid`, `oErrorCode`=10. A following correct byte 0x42 still decodes.
- Short pulse and RW:
  - E high 11 cycles with `MIN_E_HIGH`=12 → nibble ignored, `oErrorCode`=11.
  - An edge with RW=1 → no state change.
- Init error and reset: first nibble 0x2 → `oErrorCode`=01, FSM stays in `INIT3A`. Then assert `Reset`=0 asynchronously mid-byte → all outputs return to reset values immediately, and a fresh init sequence completes.
